// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the PIO-style key input block.
//   - Avalon-MM word offsets of the register map
//   - default debounce interval (1 ms at 50 MHz)
//   - helper for sizing the debounce counter
package soc_system_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RSVD    = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_addr_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  // The extra bit gives headroom so the terminal compare can never be
  // missed by a counter that is exactly wide enough for the limit.
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/soc_system_debounce.sv
// Per-key synchronizer, debouncer and press detector.
//   clk, reset : rising-edge clock, async active-high reset
//   key_raw    : raw asynchronous key level, active-low (idle high)
//   level      : debounced key level
//   press      : one-cycle strobe on the cycle the debounced level
//                falls 1->0; coincident with the level update
module soc_system_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d;

  // Synchronizer resets high so an idle key does not look pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter tracks consecutive cycles of disagreement; the level is
  // accepted when the count already sits at the last value and the input
  // still disagrees, giving exactly DEBOUNCE_CYCLES mismatched samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = level_q & ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign level = level_q;
  assign press = press_d;

endmodule

// File: rtl/soc_system_keys_in.sv
// Debounced key input peripheral with Avalon-MM slave and level IRQ.
//   clk, reset       : rising-edge clock, async active-high reset
//   address          : word offset (data / reserved / irqmask / edgecapture)
//   chipselect,
//   write_n,
//   writedata        : Avalon-MM write port, bits at/above WIDTH ignored
//   in_port          : raw active-low key levels
//   readdata         : combinational read data, zero-extended
//   irq              : registered |(edgecapture & irqmask)
module soc_system_keys_in
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_key
    soc_system_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .key_raw(in_port[i]),
      .level  (level[i]),
      .press  (press[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      irq_q     <= irq_d;
    end
  end

  // Clear is applied first and the new press OR-ed in after, so a press
  // always survives a coincident write-1-to-clear of the same bit.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en) begin
      unique case (reg_addr_e'(address))
        REG_IRQMASK: irqmask_d = writedata[WIDTH-1:0];
        REG_EDGECAP: edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        default:     ;
      endcase
    end
    edgecap_d = edgecap_d | press;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_comb begin
    readdata = '0;
    unique case (reg_addr_e'(address))
      REG_DATA:    readdata[WIDTH-1:0] = level;
      REG_RSVD:    readdata = '0;
      REG_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      REG_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:     readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_soc_system_keys_in.sv
module tb_soc_system_keys_in;

  localparam int W = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  soc_system_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Model: a key's level flips once the last N synchronized samples all
  // disagree with it. Synchronizer is a 2-deep delay of in_port.
  logic [W-1:0] m_s1, m_s2, m_lvl, m_mask, m_ecap;
  logic         m_irq;
  bit           m_hist [W][N];

  always @(posedge clk or posedge reset) begin
    logic [W-1:0] prs;
    logic         nirq;
    bit           all_diff;
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '1;
      m_mask = '0; m_ecap = '0; m_irq = 1'b0;
      for (int b = 0; b < W; b++)
        for (int k = 0; k < N; k++) m_hist[b][k] = 1'b1;
    end else begin
      nirq = |(m_ecap & m_mask);
      prs  = '0;
      for (int b = 0; b < W; b++) begin
        for (int k = N - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = m_s2[b];
        all_diff = 1'b1;
        for (int k = 0; k < N; k++)
          if (m_hist[b][k] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_lvl[b]) prs[b] = 1'b1;
          m_lvl[b] = m_s2[b];
        end
      end
      if (chipselect && !write_n) begin
        if (address == 2'd2) m_mask = writedata[W-1:0];
        if (address == 2'd3) m_ecap = m_ecap & ~writedata[W-1:0];
      end
      m_ecap = m_ecap | prs;
      m_s2 = m_s1;
      m_s1 = in_port;
      m_irq = nirq;
    end
  end

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[W-1:0] = m_lvl;
      2'd2: r[W-1:0] = m_mask;
      2'd3: r[W-1:0] = m_ecap;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; then compare DUT against the model, 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("model_readdata", readdata, exp_read(address));
    check("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ticks(3);

    // Reset state
    chk_rd("rst_data", 2'd0, 32'h0000_000F);
    chk_rd("rst_mask", 2'd2, 32'h0);
    chk_rd("rst_ecap", 2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Press key 0: accepted on the 6th edge after the change
    in_port = 4'hE;
    address = 2'd0;
    ticks(5);
    chk_rd("press0_early", 2'd0, 32'h0000_000F);
    tick();
    chk_rd("press0_data", 2'd0, 32'h0000_000E);
    chk_rd("press0_ecap", 2'd3, 32'h1);
    chk_irq("press0_irq", 1'b0);
    wr(2'd2, 32'h1);
    chk_irq("mask_irq_same", 1'b0);
    tick();
    chk_irq("mask_irq_next", 1'b1);

    // 3-cycle glitch on key 1 is rejected
    in_port = 4'hC;
    ticks(3);
    in_port = 4'hE;
    ticks(8);
    chk_rd("glitch_data", 2'd0, 32'h0000_000E);
    chk_rd("glitch_ecap", 2'd3, 32'h1);
    chk_irq("glitch_irq", 1'b1);

    // Release key 0 (no capture), then press it again with a coincident clear
    in_port = 4'hF;
    ticks(6);
    chk_rd("release_data", 2'd0, 32'h0000_000F);
    chk_rd("release_ecap", 2'd3, 32'h1);
    in_port = 4'hE;
    ticks(5);
    wr(2'd3, 32'h1);
    chk_rd("setwins_data", 2'd0, 32'h0000_000E);
    chk_rd("setwins_ecap", 2'd3, 32'h1);
    wr(2'd3, 32'hF);
    chk_rd("clear_ecap", 2'd3, 32'h0);
    chk_irq("clear_irq_same", 1'b1);
    tick();
    chk_irq("clear_irq_next", 1'b0);

    // Press key 3, then key 0 press coincides with clear-all: bit 3 clears, bit 0 sets
    in_port = 4'hF;
    ticks(6);
    in_port = 4'h7;
    ticks(6);
    chk_rd("press3_ecap", 2'd3, 32'h8);
    in_port = 4'h6;
    ticks(5);
    wr(2'd3, 32'hF);
    chk_rd("mixed_ecap", 2'd3, 32'h1);
    wr(2'd3, 32'hF);
    ticks(2);

    // Reset mid-count with key 2 held low
    in_port = 4'hB;
    ticks(3);
    reset = 1'b1;
    #1;
    chk_rd("midrst_data", 2'd0, 32'h0000_000F);
    chk_rd("midrst_mask", 2'd2, 32'h0);
    chk_rd("midrst_ecap", 2'd3, 32'h0);
    chk_irq("midrst_irq", 1'b0);
    ticks(2);
    reset = 1'b0;
    address = 2'd3;
    ticks(5);
    chk_rd("rel_ecap_early", 2'd3, 32'h0);
    tick();
    chk_rd("rel_ecap", 2'd3, 32'h4);
    chk_rd("rel_data", 2'd0, 32'h0000_000B);
    ticks(20);
    chk_rd("rel_ecap_once", 2'd3, 32'h4);

    // Reserved offset and upper writedata bits
    wr(2'd1, 32'hFFFF_FFFF);
    chk_rd("rsvd_read", 2'd1, 32'h0);
    chk_rd("rsvd_data", 2'd0, 32'h0000_000B);
    chk_rd("rsvd_mask", 2'd2, 32'h0);
    chk_rd("rsvd_ecap", 2'd3, 32'h4);
    wr(2'd2, 32'hFFFF_FFF5);
    chk_rd("mask_upper", 2'd2, 32'h5);
    tick();
    chk_irq("mask5_irq", 1'b1);
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
